// File: rtl/mem_arb_pkg.sv
// Shared types and helpers for the mem_ctrl request arbiter.
//   arb_state_e : transaction sequencer states
//   DefAddrW/DefDataW : default widths matching mem_ctrl Addr_in/Data_in
//   cnt_width() : width of the shared down-counter for hold/timeout/gap
package mem_arb_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StWrData,
      StWrEnd,
      StRdCmd,
      StRdWait,
      StResp,
      StGap
   } arb_state_e;

   localparam int unsigned DefAddrW = 16;
   localparam int unsigned DefDataW = 32;

   // One counter serves all three timed phases, so size it for the longest.
   function automatic int unsigned cnt_width(input int unsigned wr_hold,
                                             input int unsigned rd_timeout,
                                             input int unsigned gap_cyc);
      int unsigned max_v;
      max_v = wr_hold;
      if (rd_timeout > max_v) max_v = rd_timeout;
      if (gap_cyc > max_v) max_v = gap_cyc;
      return unsigned'($clog2(max_v + 1));
   endfunction

endpackage

// File: rtl/mem_rr_pick.sv
// Combinational round-robin winner select.
//   req_i : request vector
//   ptr_i : highest-priority index this round
//   gnt_o : one-hot winner, idx_o : winner index, any_o : at least one request
module mem_rr_pick #(
   parameter int unsigned NumReq = 2,
   parameter int unsigned IdxW   = 1
) (
   input  logic [NumReq-1:0] req_i,
   input  logic [IdxW-1:0]   ptr_i,
   output logic [NumReq-1:0] gnt_o,
   output logic [IdxW-1:0]   idx_o,
   output logic              any_o
);

   // First pass covers indices at/after the pointer, second pass wraps to the
   // ones below it; the first hit wins.
   always_comb begin
      gnt_o = '0;
      idx_o = '0;
      any_o = 1'b0;
      for (int unsigned i = 0; i < NumReq; i++) begin
         if (!any_o && req_i[i] && (i >= 32'(ptr_i))) begin
            any_o    = 1'b1;
            gnt_o[i] = 1'b1;
            idx_o    = IdxW'(i);
         end
      end
      for (int unsigned i = 0; i < NumReq; i++) begin
         if (!any_o && req_i[i]) begin
            any_o    = 1'b1;
            gnt_o[i] = 1'b1;
            idx_o    = IdxW'(i);
         end
      end
   end

endmodule

// File: rtl/mem_req_arbiter.sv
// Round-robin arbiter sharing one mem_ctrl between NUM_REQ requesters.
//   req_valid/req_ready      : per-requester handshake, req_ready one-hot in IDLE
//   req_rdnwr/addr/wdata     : per-requester command, packed per requester
//   rsp_valid/rdata/err      : one-cycle completion pulse to the granted requester
//   mc_cmd_n/rdnwr/data_in_vld/addr/wdata : registered drive to mem_ctrl
//   mc_rdata/mc_rdata_vld    : read return from mem_ctrl
module mem_req_arbiter
   import mem_arb_pkg::*;
#(
   parameter int unsigned NUM_REQ    = 2,
   parameter int unsigned ADDR_W     = DefAddrW,
   parameter int unsigned DATA_W     = DefDataW,
   parameter int unsigned WR_HOLD    = 20,
   parameter int unsigned RD_TIMEOUT = 8,
   parameter int unsigned GAP_CYC    = 1
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [NUM_REQ-1:0]        req_valid,
   output logic [NUM_REQ-1:0]        req_ready,
   input  logic [NUM_REQ-1:0]        req_rdnwr,
   input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
   input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
   output logic [NUM_REQ-1:0]        rsp_valid,
   output logic [DATA_W-1:0]         rsp_rdata,
   output logic                      rsp_err,
   output logic                      mc_cmd_n,
   output logic                      mc_rdnwr,
   output logic                      mc_data_in_vld,
   output logic [ADDR_W-1:0]         mc_addr,
   output logic [DATA_W-1:0]         mc_wdata,
   input  logic [DATA_W-1:0]         mc_rdata,
   input  logic                      mc_rdata_vld
);

   localparam int unsigned IdxW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int unsigned CntW = cnt_width(WR_HOLD, RD_TIMEOUT, GAP_CYC);

   arb_state_e state_q, state_d;
   logic [IdxW-1:0] ptr_q, ptr_d;
   logic [IdxW-1:0] grant_q, grant_d;
   logic [CntW-1:0] cnt_q, cnt_d;

   logic                mc_cmd_n_q, mc_cmd_n_d;
   logic                mc_rdnwr_q, mc_rdnwr_d;
   logic                mc_din_vld_q, mc_din_vld_d;
   logic [ADDR_W-1:0]   mc_addr_q, mc_addr_d;
   logic [DATA_W-1:0]   mc_wdata_q, mc_wdata_d;
   logic [NUM_REQ-1:0]  rsp_valid_q, rsp_valid_d;
   logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
   logic                rsp_err_q, rsp_err_d;

   logic [NUM_REQ-1:0]  pick_gnt;
   logic [IdxW-1:0]     pick_idx;
   logic                pick_any;
   logic                sel_rdnwr;
   logic [ADDR_W-1:0]   sel_addr;
   logic [DATA_W-1:0]   sel_wdata;

   mem_rr_pick #(
      .NumReq (NUM_REQ),
      .IdxW   (IdxW)
   ) u_pick (
      .req_i (req_valid),
      .ptr_i (ptr_q),
      .gnt_o (pick_gnt),
      .idx_o (pick_idx),
      .any_o (pick_any)
   );

   // Gated by rst_n so nothing appears accepted while reset is held.
   assign req_ready = (state_q == StIdle && rst_n) ? pick_gnt : '0;

   // Mux the winner's command fields using the one-hot grant.
   always_comb begin
      sel_rdnwr = 1'b0;
      sel_addr  = '0;
      sel_wdata = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         if (pick_gnt[i]) begin
            sel_rdnwr = req_rdnwr[i];
            sel_addr  = req_addr[i*ADDR_W +: ADDR_W];
            sel_wdata = req_wdata[i*DATA_W +: DATA_W];
         end
      end
   end

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      ptr_d        = ptr_q;
      grant_d      = grant_q;
      mc_cmd_n_d   = 1'b1;
      mc_din_vld_d = 1'b0;
      mc_rdnwr_d   = mc_rdnwr_q;
      mc_addr_d    = mc_addr_q;
      mc_wdata_d   = mc_wdata_q;
      rsp_valid_d  = '0;
      rsp_rdata_d  = '0;
      rsp_err_d    = 1'b0;

      case (state_q)
         StIdle: begin
            if (pick_any) begin
               grant_d    = pick_idx;
               mc_addr_d  = sel_addr;
               mc_wdata_d = sel_wdata;
               if (sel_rdnwr) begin
                  state_d = StRdCmd;
               end else begin
                  state_d = StWrData;
                  cnt_d   = CntW'(WR_HOLD - 1);
               end
            end
         end
         StWrData: begin
            if (cnt_q == '0) state_d = StWrEnd;
            else             cnt_d   = cnt_q - 1'b1;
         end
         StWrEnd: state_d = StResp;
         StRdCmd: begin
            state_d = StRdWait;
            cnt_d   = CntW'(RD_TIMEOUT - 1);
         end
         StRdWait: begin
            // Data arriving on the final wait cycle still counts as success.
            if (mc_rdata_vld) begin
               state_d     = StResp;
               rsp_rdata_d = mc_rdata;
            end else if (cnt_q == '0) begin
               state_d   = StResp;
               rsp_err_d = 1'b1;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         StResp: begin
            state_d = StGap;
            cnt_d   = CntW'(GAP_CYC - 1);
            ptr_d   = (grant_q == IdxW'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;
         end
         StGap: begin
            if (cnt_q == '0) state_d = StIdle;
            else             cnt_d   = cnt_q - 1'b1;
         end
         default: state_d = StIdle;
      endcase

      // Registered outputs are decoded from the next state so each one is
      // valid during the same cycle as the state it belongs to.
      case (state_d)
         StWrData: begin
            mc_cmd_n_d   = 1'b0;
            mc_din_vld_d = 1'b1;
            mc_rdnwr_d   = 1'b0;
         end
         StWrEnd: begin
            mc_cmd_n_d = 1'b0;
            mc_rdnwr_d = 1'b0;
         end
         StRdCmd: begin
            mc_cmd_n_d = 1'b0;
            mc_rdnwr_d = 1'b1;
         end
         StRdWait: mc_rdnwr_d = 1'b1;
         StResp: begin
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
               rsp_valid_d[i] = (grant_d == IdxW'(i));
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= StIdle;
         ptr_q        <= '0;
         grant_q      <= '0;
         cnt_q        <= '0;
         mc_cmd_n_q   <= 1'b1;
         mc_rdnwr_q   <= 1'b0;
         mc_din_vld_q <= 1'b0;
         mc_addr_q    <= '0;
         mc_wdata_q   <= '0;
         rsp_valid_q  <= '0;
         rsp_rdata_q  <= '0;
         rsp_err_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         ptr_q        <= ptr_d;
         grant_q      <= grant_d;
         cnt_q        <= cnt_d;
         mc_cmd_n_q   <= mc_cmd_n_d;
         mc_rdnwr_q   <= mc_rdnwr_d;
         mc_din_vld_q <= mc_din_vld_d;
         mc_addr_q    <= mc_addr_d;
         mc_wdata_q   <= mc_wdata_d;
         rsp_valid_q  <= rsp_valid_d;
         rsp_rdata_q  <= rsp_rdata_d;
         rsp_err_q    <= rsp_err_d;
      end
   end

   assign mc_cmd_n       = mc_cmd_n_q;
   assign mc_rdnwr       = mc_rdnwr_q;
   assign mc_data_in_vld = mc_din_vld_q;
   assign mc_addr        = mc_addr_q;
   assign mc_wdata       = mc_wdata_q;
   assign rsp_valid      = rsp_valid_q;
   assign rsp_rdata      = rsp_rdata_q;
   assign rsp_err        = rsp_err_q;

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Self-checking bench for mem_req_arbiter (2 requesters, default timing).
module tb_mem_req_arbiter;

   localparam int NR = 2;
   localparam int AW = 16;
   localparam int DW = 32;
   localparam int WR_HOLD = 20;
   localparam int RD_TIMEOUT = 8;
   localparam int GAP_CYC = 1;

   logic              clk;
   logic              rst_n;
   logic [NR-1:0]     req_valid;
   logic [NR-1:0]     req_ready;
   logic [NR-1:0]     req_rdnwr;
   logic [NR*AW-1:0]  req_addr;
   logic [NR*DW-1:0]  req_wdata;
   logic [NR-1:0]     rsp_valid;
   logic [DW-1:0]     rsp_rdata;
   logic              rsp_err;
   logic              mc_cmd_n;
   logic              mc_rdnwr;
   logic              mc_data_in_vld;
   logic [AW-1:0]     mc_addr;
   logic [DW-1:0]     mc_wdata;
   logic [DW-1:0]     mc_rdata;
   logic              mc_rdata_vld;

   typedef struct {
      int          idx;
      logic [31:0] rdata;
      logic        err;
      int          lat;
   } exp_t;

   exp_t sb_q[$];
   int   checks = 0;
   int   failures = 0;
   int   cyc = 0;

   mem_req_arbiter #(
      .NUM_REQ    (NR),
      .ADDR_W     (AW),
      .DATA_W     (DW),
      .WR_HOLD    (WR_HOLD),
      .RD_TIMEOUT (RD_TIMEOUT),
      .GAP_CYC    (GAP_CYC)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .req_valid      (req_valid),
      .req_ready      (req_ready),
      .req_rdnwr      (req_rdnwr),
      .req_addr       (req_addr),
      .req_wdata      (req_wdata),
      .rsp_valid      (rsp_valid),
      .rsp_rdata      (rsp_rdata),
      .rsp_err        (rsp_err),
      .mc_cmd_n       (mc_cmd_n),
      .mc_rdnwr       (mc_rdnwr),
      .mc_data_in_vld (mc_data_in_vld),
      .mc_addr        (mc_addr),
      .mc_wdata       (mc_wdata),
      .mc_rdata       (mc_rdata),
      .mc_rdata_vld   (mc_rdata_vld)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #400000;
      $display("FAIL watchdog: sim time exceeded, got no finish want finish");
      $fatal(1, "watchdog");
   end

   // Drives one request from requester r and follows it to its response.
   // vld_cyc: cycle (accept=0) in which mc_rdata_vld is driven; -1 never, -2 always.
   task automatic run_txn(input int r, input bit rd, input logic [15:0] a,
                          input logic [31:0] d, input int vld_cyc, input logic [31:0] mdata,
                          output bit got, output int lat, output logic [NR-1:0] rv,
                          output logic [31:0] rdat, output logic rerr, output int n_cmd,
                          output int n_din, output int n_rdcmd, output bit data_ok);
      bit acc;
      got = 0; lat = -1; rv = '0; rdat = '0; rerr = 1'b0;
      n_cmd = 0; n_din = 0; n_rdcmd = 0; data_ok = 1; acc = 0;
      @(posedge clk); #1;
      req_rdnwr[r] = rd;
      req_addr[r*AW +: AW] = a;
      req_wdata[r*DW +: DW] = d;
      req_valid[r] = 1'b1;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (req_ready[r]) begin
            acc = 1;
            break;
         end
         @(posedge clk); #1;
      end
      if (!acc) begin
         req_valid[r] = 1'b0;
         return;
      end
      for (int n = 1; n <= 60; n++) begin
         @(posedge clk); #1;
         req_valid[r] = 1'b0;
         mc_rdata_vld = (vld_cyc == -2) || (n == vld_cyc);
         mc_rdata = mc_rdata_vld ? mdata : 32'h0BAD_0BAD;
         @(negedge clk);
         if (!mc_cmd_n) n_cmd++;
         if (!mc_cmd_n && mc_rdnwr) n_rdcmd++;
         if (mc_data_in_vld) begin
            n_din++;
            if (mc_addr !== a || mc_wdata !== d) data_ok = 0;
         end
         if (|rsp_valid) begin
            got = 1; lat = n; rv = rsp_valid; rdat = rsp_rdata; rerr = rsp_err;
            break;
         end
      end
      @(posedge clk); #1;
      mc_rdata_vld = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      req_valid = '1;
      req_rdnwr = '0;
      req_addr = '0;
      req_wdata = '0;
      mc_rdata = '0;
      mc_rdata_vld = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checks++; if (req_ready !== 2'b00) begin failures++; $display("FAIL rst_ready: got %b want 00", req_ready); end
      checks++; if (mc_cmd_n !== 1'b1) begin failures++; $display("FAIL rst_cmd_n: got %b want 1", mc_cmd_n); end
      checks++; if (mc_rdnwr !== 1'b0) begin failures++; $display("FAIL rst_rdnwr: got %b want 0", mc_rdnwr); end
      checks++; if (mc_data_in_vld !== 1'b0) begin failures++; $display("FAIL rst_din_vld: got %b want 0", mc_data_in_vld); end
      checks++; if (mc_addr !== 16'h0) begin failures++; $display("FAIL rst_addr: got %h want 0", mc_addr); end
      checks++; if (mc_wdata !== 32'h0) begin failures++; $display("FAIL rst_wdata: got %h want 0", mc_wdata); end
      checks++; if (rsp_valid !== 2'b00) begin failures++; $display("FAIL rst_rsp_valid: got %b want 00", rsp_valid); end
      checks++; if (rsp_rdata !== 32'h0 || rsp_err !== 1'b0) begin failures++; $display("FAIL rst_rsp: got %h/%b want 0/0", rsp_rdata, rsp_err); end
      req_valid = '0;
      @(posedge clk); #1;
      rst_n = 1'b1;
   endtask

   task automatic test_write();
      bit got, dok; int lat, nc, nd, nr; logic [NR-1:0] rv; logic [31:0] rd; logic er; exp_t e;
      sb_q.push_back('{idx: 0, rdata: 32'h0, err: 1'b0, lat: WR_HOLD + 2});
      run_txn(0, 1'b0, 16'h1001, 32'hA5A5A5A5, -1, 32'h0, got, lat, rv, rd, er, nc, nd, nr, dok);
      e = sb_q.pop_front();
      checks++; if (!got) begin failures++; $display("FAIL wr_done: got none want response"); end
      checks++; if (lat !== e.lat) begin failures++; $display("FAIL wr_lat: got %0d want %0d", lat, e.lat); end
      checks++; if (rv !== (2'b01 << e.idx)) begin failures++; $display("FAIL wr_rsp_valid: got %b want idx %0d", rv, e.idx); end
      checks++; if (rd !== e.rdata || er !== e.err) begin failures++; $display("FAIL wr_rsp: got %h/%b want %h/%b", rd, er, e.rdata, e.err); end
      checks++; if (nd !== WR_HOLD) begin failures++; $display("FAIL wr_din_cycles: got %0d want %0d", nd, WR_HOLD); end
      checks++; if (nc !== WR_HOLD + 1) begin failures++; $display("FAIL wr_cmd_cycles: got %0d want %0d", nc, WR_HOLD + 1); end
      checks++; if (!dok || nr !== 0) begin failures++; $display("FAIL wr_bus: got data_ok=%0d rd_cmd=%0d want 1/0", dok, nr); end
   endtask

   task automatic test_read();
      int vld_tab[3] = '{4, 2, RD_TIMEOUT + 1};
      logic [31:0] dat_tab[3] = '{32'hDEADBEEF, 32'h12345678, 32'hCAFEF00D};
      bit got, dok; int lat, nc, nd, nr; logic [NR-1:0] rv; logic [31:0] rd; logic er; exp_t e;
      for (int t = 0; t < 3; t++) begin
         sb_q.push_back('{idx: 1, rdata: dat_tab[t], err: 1'b0, lat: vld_tab[t] + 1});
         run_txn(1, 1'b1, 16'h2000, 32'h0, vld_tab[t], dat_tab[t], got, lat, rv, rd, er, nc, nd,
                 nr, dok);
         e = sb_q.pop_front();
         checks++; if (!got || lat !== e.lat) begin failures++; $display("FAIL rd_lat[%0d]: got %0d want %0d", t, lat, e.lat); end
         checks++; if (rv !== (2'b01 << e.idx)) begin failures++; $display("FAIL rd_rsp_valid[%0d]: got %b want idx %0d", t, rv, e.idx); end
         checks++; if (rd !== e.rdata || er !== e.err) begin failures++; $display("FAIL rd_rsp[%0d]: got %h/%b want %h/%b", t, rd, er, e.rdata, e.err); end
         checks++; if (nc !== 1 || nr !== 1 || nd !== 0) begin failures++; $display("FAIL rd_cmd[%0d]: got cmd=%0d rdcmd=%0d din=%0d want 1/1/0", t, nc, nr, nd); end
      end
   endtask

   task automatic test_timeout();
      bit got, dok; int lat, nc, nd, nr; logic [NR-1:0] rv; logic [31:0] rd; logic er; exp_t e;
      sb_q.push_back('{idx: 1, rdata: 32'h0, err: 1'b1, lat: RD_TIMEOUT + 2});
      run_txn(1, 1'b1, 16'h3000, 32'h0, -1, 32'h0, got, lat, rv, rd, er, nc, nd, nr, dok);
      e = sb_q.pop_front();
      checks++; if (!got || lat !== e.lat) begin failures++; $display("FAIL to_lat: got %0d want %0d", lat, e.lat); end
      checks++; if (rd !== e.rdata || er !== e.err) begin failures++; $display("FAIL to_rsp: got %h/%b want %h/%b", rd, er, e.rdata, e.err); end
      checks++; if (rv !== (2'b01 << e.idx)) begin failures++; $display("FAIL to_rsp_valid: got %b want idx %0d", rv, e.idx); end
   endtask

   task automatic test_stray_vld();
      bit got, dok; int lat, nc, nd, nr, bad; logic [NR-1:0] rv; logic [31:0] rd; logic er; exp_t e;
      bad = 0;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         mc_rdata_vld = 1'b1;
         mc_rdata = 32'hFFFF0000;
         @(negedge clk);
         if (rsp_valid !== 2'b00 || mc_cmd_n !== 1'b1) bad++;
      end
      mc_rdata_vld = 1'b0;
      checks++; if (bad != 0) begin failures++; $display("FAIL stray_idle: got %0d bad cycles want 0", bad); end
      sb_q.push_back('{idx: 1, rdata: 32'h0, err: 1'b0, lat: WR_HOLD + 2});
      run_txn(1, 1'b0, 16'h4444, 32'h5A5A0001, -2, 32'hFFFF0000, got, lat, rv, rd, er, nc, nd, nr,
              dok);
      e = sb_q.pop_front();
      checks++; if (!got || lat !== e.lat) begin failures++; $display("FAIL stray_wr_lat: got %0d want %0d", lat, e.lat); end
      checks++; if (rd !== e.rdata || er !== e.err || rv !== (2'b01 << e.idx)) begin failures++; $display("FAIL stray_wr_rsp: got %b %h/%b want idx %0d 0/0", rv, rd, er, e.idx); end
      checks++; if (nd !== WR_HOLD || !dok) begin failures++; $display("FAIL stray_wr_din: got %0d ok=%0d want %0d ok=1", nd, dok, WR_HOLD); end
   endtask

   // Both requesters issue writes back to back after a fresh reset.
   task automatic test_back_to_back();
      int mptr, n_rsp, last_rsp, acc_cyc, prev_idx, w;
      exp_t e;
      @(posedge clk); #1;
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      req_rdnwr = '0;
      req_addr = {16'hB001, 16'hA001};
      req_wdata = {32'h11111111, 32'h00000000};
      req_valid = 2'b11;
      mptr = 0; n_rsp = 0; last_rsp = -100; acc_cyc = 0; prev_idx = -1;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (cyc == last_rsp + 1) begin
            checks++; if (mc_cmd_n !== 1'b1 || mc_data_in_vld !== 1'b0) begin failures++; $display("FAIL b2b_gap: got cmd_n=%b din=%b want 1/0", mc_cmd_n, mc_data_in_vld); end
         end
         if (|req_ready) begin
            w = mptr;  // both valid, so the pointer position wins
            checks++; if (req_ready !== (2'b01 << w)) begin failures++; $display("FAIL b2b_ready: got %b want idx %0d", req_ready, w); end
            if (n_rsp > 0) begin
               checks++; if (cyc - last_rsp !== GAP_CYC + 1) begin failures++; $display("FAIL b2b_spacing: got %0d want %0d", cyc - last_rsp, GAP_CYC + 1); end
            end
            sb_q.push_back('{idx: w, rdata: 32'h0, err: 1'b0, lat: WR_HOLD + 2});
            acc_cyc = cyc;
         end
         if (|rsp_valid) begin
            if (sb_q.size() == 0) begin
               checks++; failures++; $display("FAIL b2b_unexpected: got %b want none", rsp_valid);
            end else begin
               e = sb_q.pop_front();
               checks++; if (rsp_valid !== (2'b01 << e.idx)) begin failures++; $display("FAIL b2b_rsp: got %b want idx %0d", rsp_valid, e.idx); end
               checks++; if (cyc - acc_cyc !== e.lat) begin failures++; $display("FAIL b2b_lat: got %0d want %0d", cyc - acc_cyc, e.lat); end
               checks++; if (e.idx == prev_idx) begin failures++; $display("FAIL b2b_repeat: got idx %0d twice want alternation", e.idx); end
               prev_idx = e.idx;
               mptr = (e.idx + 1) % NR;
            end
            last_rsp = cyc;
            n_rsp++;
            if (n_rsp == 4) break;
         end
      end
      checks++; if (n_rsp != 4) begin failures++; $display("FAIL b2b_count: got %0d want 4", n_rsp); end
      @(posedge clk); #1;
      req_valid = '0;
      sb_q.delete();
      repeat (3) @(posedge clk);
   endtask

   task automatic test_reset_mid();
      bit got, dok, acc; int lat, nc, nd, nr, bad, t0; logic [NR-1:0] rv; logic [31:0] rd; logic er;
      // Serve requester 0 so the pointer sits at 1 before the reset.
      run_txn(0, 1'b0, 16'h0123, 32'h01010101, -1, 32'h0, got, lat, rv, rd, er, nc, nd, nr, dok);
      checks++; if (!got || rv !== 2'b01) begin failures++; $display("FAIL rm_pre: got %b want 01", rv); end
      @(posedge clk); #1;
      req_rdnwr[1] = 1'b0;
      req_valid[1] = 1'b1;
      acc = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (req_ready[1]) begin acc = 1; break; end
      end
      checks++; if (!acc) begin failures++; $display("FAIL rm_accept: got no accept want accept"); end
      @(posedge clk); #1;
      req_valid = '0;
      repeat (5) @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      checks++; if (mc_cmd_n !== 1'b1 || mc_data_in_vld !== 1'b0) begin failures++; $display("FAIL rm_async: got cmd_n=%b din=%b want 1/0", mc_cmd_n, mc_data_in_vld); end
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      bad = 0;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         if (rsp_valid !== 2'b00 || mc_cmd_n !== 1'b1) bad++;
      end
      checks++; if (bad != 0) begin failures++; $display("FAIL rm_dropped: got %0d bad cycles want 0", bad); end
      @(posedge clk); #1;
      req_valid = 2'b11;
      @(negedge clk);
      checks++; if (req_ready !== 2'b01) begin failures++; $display("FAIL rm_ptr: got %b want 01", req_ready); end
      t0 = cyc;
      @(posedge clk); #1;
      req_valid = '0;
      got = 0;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (|rsp_valid) begin got = 1; rv = rsp_valid; lat = cyc - t0; break; end
      end
      checks++; if (!got || rv !== 2'b01 || lat !== WR_HOLD + 2) begin failures++; $display("FAIL rm_post: got %b lat %0d want 01 lat %0d", rv, lat, WR_HOLD + 2); end
   endtask

   initial begin
      test_reset();
      test_write();
      test_read();
      test_timeout();
      test_stray_vld();
      test_back_to_back();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/mem_req_arbiter.md
Name: mem_req_arbiter

Overview:
- Round-robin scheduler sharing one mem_ctrl instance between NUM_REQ requesters.
- Accepts one request at a time over a valid/ready handshake.
- Sequences the mem_ctrl command strobe (cmd_n), write-data hold and read-response wait, then returns a single-cycle response to the granted requester.
- Sits between the bus-side clients and mem_ctrl's Addr_in/Data_in/cmd_n/RDnWR/Data_in_vld/Data_out/data_out_vld pins.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- ADDR_W, 16, address width (matches mem_ctrl Addr_in).
- DATA_W, 32, data width (matches mem_ctrl Data_in/Data_out).
- WR_HOLD, 20, cycles cmd_n=0 and Data_in_vld=1 are held for a write (>=1).
- RD_TIMEOUT, 8, max cycles waiting for data_out_vld before an error response (>=1).
- GAP_CYC, 1, idle cycles with cmd_n=1 between transactions (>=1).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_ready  out  NUM_REQ  one-hot accept; high only for the winner in IDLE.
- req_rdnwr  in  NUM_REQ  1=read, 0=write, per requester.
- req_addr  in  NUM_REQ*ADDR_W  packed addresses; requester i at slice [i*ADDR_W +: ADDR_W].
- req_wdata  in  NUM_REQ*DATA_W  packed write data.
- rsp_valid  out  NUM_REQ  one-hot, one-cycle completion pulse.
- rsp_rdata  out  DATA_W  read data; 0 for writes and timeouts.
- rsp_err  out  1  read timeout flag, qualified by rsp_valid.
- mc_cmd_n  out  1  to mem_ctrl cmd_n, active-low.
- mc_rdnwr  out  1  to mem_ctrl RDnWR.
- mc_data_in_vld  out  1  to mem_ctrl Data_in_vld.
- mc_addr  out  ADDR_W  to mem_ctrl Addr_in.
- mc_wdata  out  DATA_W  to mem_ctrl Data_in.
- mc_rdata  in  DATA_W  from mem_ctrl Data_out.
- mc_rdata_vld  in  1  from mem_ctrl data_out_vld.

Behaviour:
- Reset (asynchronous, rst_n=0) sets every output to its reset value:
  - mc_cmd_n=1, mc_rdnwr=0, mc_data_in_vld=0, mc_addr=0, mc_wdata=0.
  - req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0.
  - rr pointer=0, state=IDLE.
  - Any in-flight transaction is dropped with no response.
- All mc_* and rsp_* outputs are registered. req_ready is combinational from state, req_valid and the pointer.
- States and transitions:
  - IDLE: winner = first asserted req_valid at or after the pointer, wrapping. req_ready[winner]=1 combinationally. On that edge, latch grant index, rdnwr, addr, wdata. Go to WR_DATA (write) or RD_CMD (read). With no valid request, stay in IDLE.
  - WR_DATA: mc_cmd_n=0, mc_rdnwr=0, mc_data_in_vld=1, mc_addr/mc_wdata = latched values, for exactly WR_HOLD cycles (down-counter). Then go to WR_END.
  - WR_END: 1 cycle; mc_data_in_vld=0, mc_cmd_n=0. Then go to RESP.
  - RD_CMD: 1 cycle; mc_cmd_n=0, mc_rdnwr=1, mc_addr = latched address. Then go to RD_WAIT.
  - RD_WAIT: mc_cmd_n=1, mc_rdnwr held at 1.
    - mc_rdata_vld=1 sampled: capture mc_rdata, go to RESP, err=0.
    - RD_TIMEOUT cycles elapse without vld: go to RESP, err=1, rdata=0.
  - RESP: 1 cycle; rsp_valid[grant]=1, rsp_rdata, rsp_err. Pointer = (grant+1) mod NUM_REQ. Then go to GAP.
  - GAP: GAP_CYC cycles; mc_cmd_n=1, mc_data_in_vld=0. Then go to IDLE.
- Latency, with the accept cycle numbered 0:
  - Write: rsp_valid in cycle WR_HOLD+2.
  - Read: rsp_valid in cycle k+1, where k is the cycle in which vld is sampled in RD_WAIT (k>=2).
  - Read timeout: rsp_valid in cycle RD_TIMEOUT+2.
- mc_rdata_vld outside RD_WAIT is ignored.
- Requesters hold req_* stable while req_valid=1 and not accepted. Deasserting req_valid before acceptance is legal and causes no error.
- Simultaneous requests: strict round-robin from the pointer. A requester that was just served has lowest priority on the next arbitration.
- A requester may assert a new request in the same cycle its rsp_valid is high. It is arbitrated on the next IDLE.
- NUM_REQ not a power of two: pointer wraps from NUM_REQ-1 to 0.

Decomposition:
- Package mem_arb_pkg:
  - state enum: IDLE, WR_DATA, WR_END, RD_CMD, RD_WAIT, RESP, GAP.
  - Default constants for ADDR_W/DATA_W.
  - Counter width function ($clog2 of max(WR_HOLD, RD_TIMEOUT, GAP_CYC)+1).
- Sub-module mem_rr_pick: combinational round-robin winner select.
  - Inputs: req vector, pointer.
  - Outputs: one-hot grant, index, any.

Test Plan:
- Single write, req 0, addr 16'h1001, data 32'hA5A5A5A5 -> mc_cmd_n=0 and mc_data_in_vld=1 for 20 cycles, mc_addr=1001; rsp_valid[0] in cycle 22; rsp_err=0.
- Read, req 1, addr 16'h2000; mem_ctrl returns 32'hDEADBEEF with vld 3 cycles after RD_CMD -> mc_cmd_n=0 for exactly 1 cycle with mc_rdnwr=1; rsp_valid[1] with rsp_rdata=DEADBEEF, rsp_err=0.
- Read with no mc_rdata_vld -> rsp_valid in cycle RD_TIMEOUT+2=10, rsp_err=1, rsp_rdata=0.
- Both requesters hold req_valid continuously (writes) -> grants alternate 0,1,0,1; no requester served twice in a row; GAP of 1 cycle with mc_cmd_n=1 between transactions.
- rst_n pulsed low mid-WR_DATA -> mc_cmd_n=1 and mc_data_in_vld=0 immediately (asynchronous); no rsp_valid; next grant goes to req 0.
- Stray mc_rdata_vld=1 during WR_DATA/IDLE -> no rsp_valid, state unaffected.
